// File: rtl/cntdiv_prog.sv
// Programmable-modulus tick generator: runtime divisor load, count enable,
// continuous or one-shot mode, start/stop control and a divided square wave.
module cntdiv_prog #(
  parameter int BITS      = 4,
  parameter int DEF_DIV   = (1 << BITS) - 1,
  parameter bit AUTOSTART = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [BITS-1:0] div_i,
  input  logic            oneshot,
  input  logic            start,
  input  logic            stop,
  output logic [BITS-1:0] cnt_o,
  output logic            tick,
  output logic            sq_o,
  output logic            busy
);

  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_RUN     = 1'b1;
  localparam logic [BITS-1:0] DEF_DIV_V = BITS'(DEF_DIV);
  localparam logic [0:0]      S_RESET   = AUTOSTART ? S_RUN : S_IDLE;

  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] div_q, div_d;
  logic            sq_q, sq_d;
  logic [0:0]      state_q, state_d;

  // Tick is decoded straight from the count so it lands on the last count of
  // the period, even in a cycle where load or stop overrides the wrap.
  assign tick  = (state_q == S_RUN) && en && (cnt_q == div_q);
  assign cnt_o = cnt_q;
  assign sq_o  = sq_q;
  assign busy  = (state_q == S_RUN);

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    sq_d    = sq_q;
    state_d = state_q;
    if (load) begin
      div_d = div_i;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (stop && state_q == S_RUN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sq_d    = 1'b0;
    end else if (start && state_q == S_IDLE) begin
      state_d = S_RUN;
    end else if (tick) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
      if (oneshot) state_d = S_IDLE;
    end else if (state_q == S_RUN && en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      div_q   <= DEF_DIV_V;
      sq_q    <= 1'b0;
      state_q <= S_RESET;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sq_q    <= sq_d;
      state_q <= state_d;
    end
  end

endmodule
